// File: rtl/multi_timekeeper.sv
// -----------------------------------------------------------------------------
// multi_timekeeper
//   A bank of independent programmable timer channels sharing one prescaler.
//   Each channel is IDLE, RUN or DONE. It counts prescaled steps up to its
//   stored period and then raises a sticky tick and a one-cycle pulse. The
//   channel either reloads (periodic mode) or stops in DONE (one-shot mode).
//
// Parameters
//   Channels : number of timer channels (1..16)
//   Width    : counter / period width in bits
//   Prescale : clk cycles per timer step (>= 1)
//
// Ports
//   clk          : system clock, rising edge
//   res          : asynchronous active-low reset
//   cfg_we       : configuration write strobe
//   cfg_ch       : channel addressed by the write
//   cfg_period   : timer steps per expiry (0 keeps the channel IDLE)
//   cfg_periodic : 1 = auto-reload, 0 = one-shot
//   cfg_en       : 1 = start the channel, 0 = stop it
//   ack          : per-channel clear of the sticky tick
//   irq_mask     : per-channel interrupt enable
//   tick         : sticky expiry flags
//   pulse        : one-cycle expiry strobes
//   busy         : channel is in RUN
//   irq          : OR of tick & irq_mask
// -----------------------------------------------------------------------------
module multi_timekeeper #(
    parameter int Channels = 4,
    parameter int Width    = 32,
    parameter int Prescale = 1,
    localparam int ChW     = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                clk,
    input  logic                res,
    input  logic                cfg_we,
    input  logic [ChW-1:0]      cfg_ch,
    input  logic [Width-1:0]    cfg_period,
    input  logic                cfg_periodic,
    input  logic                cfg_en,
    input  logic [Channels-1:0] ack,
    input  logic [Channels-1:0] irq_mask,
    output logic [Channels-1:0] tick,
    output logic [Channels-1:0] pulse,
    output logic [Channels-1:0] busy,
    output logic                irq
);

    localparam int PsW = (Prescale > 1) ? $clog2(Prescale) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Shared prescaler. Any configuration write realigns it to phase 0 so the
    // written channel expires exactly period*Prescale cycles after the write.
    // -------------------------------------------------------------------------
    logic [PsW-1:0] presc_q;
    logic [PsW-1:0] presc_d;
    logic           step;

    assign step = (presc_q == PsW'(Prescale - 1));

    always_comb begin
        presc_d = presc_q + PsW'(1);
        if (cfg_we || step) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // -------------------------------------------------------------------------
    // Timer channels
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < Channels; gi++) begin : g_ch
        state_t           state_q, state_d;
        logic [Width-1:0] count_q, count_d;
        logic [Width-1:0] period_q, period_d;
        logic             periodic_q, periodic_d;
        logic             tick_q, tick_d;
        logic             pulse_q, pulse_d;
        logic             wr;
        logic             expire;

        assign wr     = cfg_we && (cfg_ch == ChW'(gi));
        // RUN is only entered with a non-zero period, so period_q-1 is safe.
        assign expire = (state_q == RUN) && step &&
                        (count_q == period_q - Width'(1));

        always_comb begin
            state_d    = state_q;
            count_d    = count_q;
            period_d   = period_q;
            periodic_d = periodic_q;
            tick_d     = tick_q;
            pulse_d    = 1'b0;

            if (wr) begin
                // A write overrides everything, including a coincident expiry.
                period_d   = cfg_period;
                periodic_d = cfg_periodic;
                count_d    = '0;
                tick_d     = 1'b0;
                state_d    = (cfg_en && (cfg_period != '0)) ? RUN : IDLE;
            end else begin
                if (ack[gi]) begin
                    tick_d = 1'b0;
                end
                if (expire) begin
                    // Set beats a simultaneous ack.
                    tick_d  = 1'b1;
                    pulse_d = 1'b1;
                    if (periodic_q) begin
                        count_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else if ((state_q == RUN) && step) begin
                    count_d = count_q + Width'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge res) begin
            if (!res) begin
                state_q    <= IDLE;
                count_q    <= '0;
                period_q   <= '0;
                periodic_q <= 1'b0;
                tick_q     <= 1'b0;
                pulse_q    <= 1'b0;
            end else begin
                state_q    <= state_d;
                count_q    <= count_d;
                period_q   <= period_d;
                periodic_q <= periodic_d;
                tick_q     <= tick_d;
                pulse_q    <= pulse_d;
            end
        end

        assign tick[gi]  = tick_q;
        assign pulse[gi] = pulse_q;
        assign busy[gi]  = (state_q == RUN);
    end

    assign irq = |(tick & irq_mask);

endmodule

// File: tb/tb_multi_timekeeper.sv
// -----------------------------------------------------------------------------
// tb_multi_timekeeper
//   Directed bench for multi_timekeeper. Instance a_ uses Prescale=1,
//   instance b_ uses Prescale=3; both share clk and reset.
// -----------------------------------------------------------------------------
module tb_multi_timekeeper;

    logic clk;
    logic res;

    logic        a_cfg_we, a_cfg_periodic, a_cfg_en, a_irq;
    logic [1:0]  a_cfg_ch;
    logic [31:0] a_cfg_period;
    logic [3:0]  a_ack, a_irq_mask, a_tick, a_pulse, a_busy;

    logic        b_cfg_we, b_cfg_periodic, b_cfg_en, b_irq;
    logic [1:0]  b_cfg_ch;
    logic [15:0] b_cfg_period;
    logic [3:0]  b_ack, b_irq_mask, b_tick, b_pulse, b_busy;

    int n_checks = 0;
    int n_pass   = 0;

    multi_timekeeper #(.Channels(4), .Width(32), .Prescale(1)) u_dut_a (
        .clk(clk), .res(res),
        .cfg_we(a_cfg_we), .cfg_ch(a_cfg_ch), .cfg_period(a_cfg_period),
        .cfg_periodic(a_cfg_periodic), .cfg_en(a_cfg_en),
        .ack(a_ack), .irq_mask(a_irq_mask),
        .tick(a_tick), .pulse(a_pulse), .busy(a_busy), .irq(a_irq)
    );

    multi_timekeeper #(.Channels(4), .Width(16), .Prescale(3)) u_dut_b (
        .clk(clk), .res(res),
        .cfg_we(b_cfg_we), .cfg_ch(b_cfg_ch), .cfg_period(b_cfg_period),
        .cfg_periodic(b_cfg_periodic), .cfg_en(b_cfg_en),
        .ack(b_ack), .irq_mask(b_irq_mask),
        .tick(b_tick), .pulse(b_pulse), .busy(b_busy), .irq(b_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick_cyc();
        @(posedge clk);
        #1;
    endtask

    // One configuration write; returns 1 time unit after the capturing edge.
    task automatic wr(input bit sel, input int ch, input int period,
                      input bit periodic, input bit en);
        if (!sel) begin
            a_cfg_we       = 1'b1;
            a_cfg_ch       = 2'(ch);
            a_cfg_period   = 32'(period);
            a_cfg_periodic = periodic;
            a_cfg_en       = en;
        end else begin
            b_cfg_we       = 1'b1;
            b_cfg_ch       = 2'(ch);
            b_cfg_period   = 16'(period);
            b_cfg_periodic = periodic;
            b_cfg_en       = en;
        end
        $display("wr inst=%s ch=%0d period=%0d periodic=%0d en=%0d t=%0t",
                 sel ? "b" : "a", ch, period, periodic, en, $time);
        @(posedge clk);
        #1;
        a_cfg_we = 1'b0;
        b_cfg_we = 1'b0;
    endtask

    initial begin
        logic exp_tick;

        res = 1'b1;
        a_cfg_we = 0; a_cfg_ch = 0; a_cfg_period = 0; a_cfg_periodic = 0;
        a_cfg_en = 0; a_ack = 0; a_irq_mask = 0;
        b_cfg_we = 0; b_cfg_ch = 0; b_cfg_period = 0; b_cfg_periodic = 0;
        b_cfg_en = 0; b_ack = 0; b_irq_mask = 4'hF;

        // ---------------- reset ----------------
        #1 res = 1'b0;
        tick_cyc();
        tick_cyc();
        check("rst_a_tick",  a_tick,  0);
        check("rst_a_pulse", a_pulse, 0);
        check("rst_a_busy",  a_busy,  0);
        check("rst_a_irq",   a_irq,   0);
        check("rst_b_tick",  b_tick,  0);
        check("rst_b_busy",  b_busy,  0);
        res = 1'b1;
        tick_cyc();
        check("post_rst_busy", a_busy, 0);

        // ---------------- periodic ch0, period 5, ack set/clear race ----------
        wr(0, 0, 5, 1, 1);
        check("p5_busy_start", a_busy[0], 1);
        check("p5_pulse_start", a_pulse[0], 0);
        for (int k = 1; k <= 21; k++) begin
            tick_cyc();
            exp_tick = ((k >= 5) && (k <= 16)) || (k == 20);
            check($sformatf("p5_pulse_k%0d", k), a_pulse[0], (k % 5 == 0) ? 1 : 0);
            check($sformatf("p5_tick_k%0d", k),  a_tick[0],  exp_tick);
            a_ack[0] = (k == 16) || (k == 19) || (k == 20);
        end
        a_ack = '0;

        // ---------------- stop a running channel ----------------
        wr(0, 0, 5, 1, 0);
        check("stop_busy", a_busy[0], 0);
        check("stop_tick", a_tick[0], 0);
        for (int k = 1; k <= 10; k++) begin
            tick_cyc();
            check($sformatf("stop_pulse_k%0d", k), a_pulse[0], 0);
        end

        // ---------------- period 0 with enable stays IDLE ----------------
        wr(0, 2, 0, 1, 1);
        check("zero_busy", a_busy[2], 0);
        for (int k = 1; k <= 6; k++) begin
            tick_cyc();
            check($sformatf("zero_pulse_k%0d", k), a_pulse[2], 0);
            check($sformatf("zero_busy_k%0d", k),  a_busy[2],  0);
        end

        // ---------------- write coincident with expiry ----------------
        wr(0, 3, 3, 1, 1);
        tick_cyc();
        tick_cyc();
        wr(0, 3, 3, 1, 1);          // lands on the expiry edge
        check("wcol_pulse", a_pulse[3], 0);
        check("wcol_tick",  a_tick[3],  0);
        check("wcol_busy",  a_busy[3],  1);
        tick_cyc();
        tick_cyc();
        check("wcol_pulse_pre", a_pulse[3], 0);
        tick_cyc();
        check("wcol_pulse_re", a_pulse[3], 1);
        wr(0, 3, 3, 1, 0);

        // ---------------- irq masking with two channels ----------------
        a_irq_mask = 4'b0001;
        wr(0, 0, 3, 0, 1);
        wr(0, 1, 4, 0, 1);
        check("irq_k0", a_irq, 0);
        for (int k = 1; k <= 5; k++) begin
            tick_cyc();
            check($sformatf("irq_k%0d", k),   a_irq,     (k == 2) ? 1 : 0);
            check($sformatf("tick1_k%0d", k), a_tick[1], (k >= 4) ? 1 : 0);
            a_ack[0] = (k == 2);
        end
        a_ack = '0;

        // ---------------- Prescale=3 one-shot ----------------
        wr(1, 1, 2, 0, 1);
        check("ps3_busy_start", b_busy[1], 1);
        for (int k = 1; k <= 56; k++) begin
            tick_cyc();
            check($sformatf("ps3_pulse_k%0d", k), b_pulse[1], (k == 6) ? 1 : 0);
            check($sformatf("ps3_busy_k%0d", k),  b_busy[1],  (k < 6) ? 1 : 0);
            if (k == 6 || k == 56) begin
                check($sformatf("ps3_tick_k%0d", k), b_tick[1], 1);
            end
        end

        // ---------------- asynchronous reset mid-count ----------------
        wr(0, 0, 4, 1, 1);
        tick_cyc();
        tick_cyc();
        check("arst_busy_before", a_busy[0], 1);
        #1 res = 1'b0;
        #1;
        check("arst_a_tick",  a_tick,  0);
        check("arst_a_pulse", a_pulse, 0);
        check("arst_a_busy",  a_busy,  0);
        check("arst_a_irq",   a_irq,   0);
        check("arst_b_tick",  b_tick,  0);
        check("arst_b_irq",   b_irq,   0);
        #1 res = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick_cyc();
            check($sformatf("arst_pulse_k%0d", k), a_pulse, 0);
            check($sformatf("arst_busy_k%0d", k),  a_busy,  0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_timekeeper.md
MULTI_TIMEKEEPER -- requirements
Module: multi_timekeeper

Interface
REQ-001 The block SHALL have parameter Channels, default 4, meaning the number of independent timer channels (1..16).
REQ-002 The block SHALL have parameter Width, default 32, meaning the counter and period width in bits.
REQ-003 The block SHALL have parameter Prescale, default 1, meaning clk cycles per timer step (>=1).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 The block SHALL have port clk, input, 1 bit, the system clock, all logic on rising edge.
REQ-006 The block SHALL have port res, input, 1 bit, asynchronous active-low reset (asserted at 0).
REQ-007 The block SHALL have port cfg_we, input, 1 bit, configuration write strobe.
REQ-008 The block SHALL have port cfg_ch, input, $clog2(Channels) bits (min 1), target channel of the write.
REQ-009 The block SHALL have port cfg_period, input, Width bits, timer steps per expiry.
REQ-010 The block SHALL have port cfg_periodic, input, 1 bit: 1 = auto-reload, 0 = one-shot.
REQ-011 The block SHALL have port cfg_en, input, 1 bit: 1 = start the channel, 0 = stop it.
REQ-012 The block SHALL have port ack, input, Channels bits, per-channel clear of the sticky tick.
REQ-013 The block SHALL have port irq_mask, input, Channels bits, per-channel interrupt enable.
REQ-014 The block SHALL have port tick, output, Channels bits, sticky expiry flags.
REQ-015 The block SHALL have port pulse, output, Channels bits, one-cycle expiry strobes.
REQ-016 The block SHALL have port busy, output, Channels bits, high while the channel is in RUN.
REQ-017 The block SHALL have port irq, output, 1 bit, OR over tick & irq_mask (combinational from registers).

Function
REQ-018 A shared prescaler SHALL count 0..Prescale-1, wrap to 0, and assert the internal step in the cycle its value equals Prescale-1; with Prescale=1 the step is asserted every cycle.
REQ-019 Each channel SHALL hold state IDLE, RUN or DONE, a Width-bit count, the stored period and the stored mode.
REQ-020 A cfg_we on channel c SHALL, at the next edge, load period and mode, clear count, tick[c] and pulse[c], and enter RUN if cfg_en=1 and cfg_period!=0; otherwise it SHALL enter IDLE.
REQ-021 In RUN with step asserted, the count SHALL increment by 1, except when count == period-1.
REQ-022 At count == period-1 with step asserted, the next edge SHALL set tick[c]=1 and pulse[c]=1, and SHALL either clear count and stay in RUN (periodic) or hold count and enter DONE (one-shot).
REQ-023 pulse[c] SHALL be high for exactly one cycle per expiry, and expiry SHALL occur period*Prescale clk cycles after the RUN-entering write (prescaler phase aligned at 0).
REQ-024 The prescaler SHALL reset to 0 on any cfg_we so channel latency is deterministic.
REQ-025 IDLE and DONE SHALL ignore steps; only a cfg_we leaves them.
REQ-026 ack[c]=1 SHALL clear tick[c] at the next edge; if expiry of c occurs in the same cycle, set SHALL win and tick[c] SHALL remain 1.
REQ-027 A cfg_we to c in the same cycle as an expiry of c SHALL take priority: no pulse, tick[c]=0.
REQ-028 Channels SHALL be fully independent; a write or ack to one SHALL not alter another, apart from the prescaler realignment in REQ-024.
REQ-029 The count SHALL never exceed period-1; no overflow or wrap beyond period is permitted.

Reset
REQ-030 While res=0, all channels SHALL be IDLE with count=0, period=0 and mode=one-shot, the prescaler SHALL be 0, and tick, pulse, busy and irq SHALL be 0, independent of clk.
REQ-031 Deassertion of res mid-operation SHALL leave every channel IDLE until a new cfg_we arrives.

Verification
REQ-032 Prescale=1: write ch0 period=5, periodic, en -> pulse[0] at cycles 5, 10 and 15 after the write; tick[0] set at cycle 5 and stays set.
REQ-033 Prescale=3: write ch1 period=2, one-shot -> single pulse[1] at cycle 6, busy[1] falls at cycle 6, and no further pulses for 50 cycles.
REQ-034 ack[0] asserted in the cycle where ch0 expires -> tick[0] remains 1; ack in the following cycle -> tick[0]=0.
REQ-035 Write cfg_period=0 with cfg_en=1 -> channel stays IDLE, busy=0, no pulse; a write with cfg_en=0 to a running channel stops it immediately.
REQ-036 Two channels with periods 3 and 4 and irq_mask=0b01 -> irq rises only from ch0 expiry; ch1 tick is visible but does not assert irq.
REQ-037 res pulled to 0 mid-count for half a cycle -> all outputs are 0 asynchronously and no pulse follows after release.
